mem_latency_rsp: RTL and testbench
==================================

MEM_LATENCY_RSP -- requirements
Module: mem_latency_rsp

Interface
REQ-001 SHALL have parameter Latency, default 100: cycles from AR handshake to first R beat valid; legal range 1..65535.
REQ-002 SHALL have parameter MaxTxns, default 32: outstanding read bursts held; power of two, at least 2.
REQ-003 SHALL have parameters AddrWidth 48, DataWidth 512, IdWidth 3: channel widths; DataWidth is a multiple of 64.
REQ-004 SHALL have parameters MemBase 0 and MemSize 2^32: decoded window, [MemBase, MemBase+MemSize).
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 ar_valid_i / ar_ready_o  in/out  1/1  read-address handshake.
REQ-008 ar_addr_i  in  AddrWidth  burst start byte address.
REQ-009 ar_id_i  in  IdWidth  transaction ID.
REQ-010 ar_len_i  in  8  beats minus one, INCR bursts only.
REQ-011 r_valid_o / r_ready_i  out/in  1/1  read-data handshake.
REQ-012 r_data_o  out  DataWidth  beat data.
REQ-013 r_id_o  out  IdWidth  ID of the current burst.
REQ-014 r_resp_o  out  2  00 OKAY, 11 DECERR.
REQ-015 r_last_o  out  1  final beat of the burst.

Function
REQ-016 SHALL keep a 32-bit free-running cycle counter that wraps modulo 2^32.
REQ-017 On AR handshake, SHALL enqueue {addr, id, len, ts=counter}; ar_ready_o = queue not full, with no bypass.
REQ-018 Head is due when (counter - ts) mod 2^32 >= Latency; AR handshake at cycle t SHALL give the first r_valid_o exactly at cycle t+Latency with R idle.
REQ-019 FSM: IDLE (queue empty), WAIT (head not due), BURST (emitting beats); IDLE->WAIT on push, WAIT->BURST when due, BURST->WAIT/IDLE after last-beat handshake, depending on queue contents.
REQ-020 r_valid_o SHALL be 1 only in BURST; data, id, resp and last SHALL hold stable while r_valid_o & !r_ready_i.
REQ-021 An 8-bit beat counter SHALL advance on each R handshake; r_last_o = (beat == len); the head pops on the last-beat handshake.
REQ-022 Beat address = (addr with low log2(DataWidth/8) bits cleared) + beat*(DataWidth/8), AddrWidth wrap.
REQ-023 Each 64-bit lane k of r_data_o SHALL equal the beat address + 8k, zero-extended or truncated to 64 bits.
REQ-024 Burst whose start addr falls outside the window: r_resp_o = 11 and r_data_o = 0 for all its len+1 beats; otherwise r_resp_o = 00.
REQ-025 Bursts complete strictly in acceptance order regardless of ID.
REQ-026 A due next head SHALL give r_valid_o in the cycle after the previous last beat; no bubble beyond that.
REQ-027 Simultaneous push and last-beat pop SHALL both take effect; occupancy is unchanged.
REQ-028 When full, ar_ready_o = 0 until the cycle after a pop.

Reset
REQ-029 While rst_i = 1 at a clock edge: queue empties, counter = 0, beat = 0, FSM = IDLE.
REQ-030 During and after reset: ar_ready_o = 1, r_valid_o = 0, r_last_o = 0, r_data_o = 0, r_id_o = 0, r_resp_o = 0.
REQ-031 Reset mid-burst SHALL drop all queued and partial bursts without emitting further beats.

Structure
REQ-032 Queue entry struct, resp encodings and default Latency/MaxTxns belong in the shared test package, next to HBMLatency.
REQ-033 The queue SHALL be one instance of common_cells fifo_v3 (depth MaxTxns, FALL_THROUGH 0); FSM and datapath live in this module.

Verification
REQ-034 Latency=100; AR addr 0x1000, len 0, id 2 at cycle 10 -> single beat at cycle 110, lane0 = 0x1000, lane1 = 0x1008, id 2, last 1, OKAY.
REQ-035 AR addr 0x40, len 3, r_ready_i held low cycles 100-104 -> beats at 0x40/0x80/0xC0/0x100, stable while stalled, last only on the 4th beat.
REQ-036 MaxTxns=4: five ARs back-to-back, r_ready_i low -> ar_ready_o drops after the 4th; it rises in the cycle after the first pop.
REQ-037 AR addr MemBase+MemSize, len 1 -> two beats, resp 11, data 0, last on the 2nd beat.
REQ-038 Counter preloaded (via force) to 0xFFFFFFF0, AR issued -> first beat exactly Latency cycles later across the wrap.
REQ-039 rst_i pulsed during beat 2 of a len=7 burst with 3 queued -> r_valid_o = 0 the cycle after; no stale beats after release.

Source files
------------

// File: rtl/mem_latency_rsp_pkg.sv
// Shared types and defaults for the fixed-latency memory read responder.
// Queue entries use the widest address/ID so one struct serves every parameterisation.
package mem_latency_rsp_pkg;

    localparam int unsigned HBMLatency     = 100;
    localparam int unsigned DefaultLatency = 100;
    localparam int unsigned DefaultMaxTxns = 32;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StBurst = 2'd2
    } rsp_state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  id;
        logic [7:0]  len;
        logic [31:0] ts;
    } rd_txn_t;

endpackage

// File: rtl/fifo_v3.sv
// Register-based FIFO with the common_cells fifo_v3 interface.
// flush_i clears the pointers synchronously; rst_ni is the asynchronous clear.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam int unsigned         FifoDepth = (DEPTH > 0) ? DEPTH : 1;
    localparam logic [ADDR_DEPTH-1:0] PtrLast = ADDR_DEPTH'(FifoDepth - 1);
    localparam logic [ADDR_DEPTH-1:0] PtrOne  = ADDR_DEPTH'(1);
    localparam logic [ADDR_DEPTH:0]   CntOne  = (ADDR_DEPTH + 1)'(1);
    localparam logic [ADDR_DEPTH:0]   CntFull = (ADDR_DEPTH + 1)'(FifoDepth);

    logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d, write_ptr_q, write_ptr_d;
    logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
    logic                  mem_we;
    logic                  unused_testmode;
    dtype                  mem_q [FifoDepth];

    assign unused_testmode = testmode_i;
    assign usage_o = status_cnt_q[ADDR_DEPTH-1:0];
    assign full_o  = (status_cnt_q == CntFull);
    assign empty_o = (status_cnt_q == '0) & ~(FALL_THROUGH & push_i);

    always_comb begin
        read_ptr_d   = read_ptr_q;
        write_ptr_d  = write_ptr_q;
        status_cnt_d = status_cnt_q;
        mem_we       = 1'b0;
        data_o       = mem_q[read_ptr_q];
        if (push_i && !full_o) begin
            mem_we       = 1'b1;
            write_ptr_d  = (write_ptr_q == PtrLast) ? '0 : write_ptr_q + PtrOne;
            status_cnt_d = status_cnt_q + CntOne;
        end
        if (pop_i && !empty_o) begin
            read_ptr_d   = (read_ptr_q == PtrLast) ? '0 : read_ptr_q + PtrOne;
            status_cnt_d = status_cnt_q - CntOne;
        end
        if (push_i && pop_i && !full_o && !empty_o) begin
            status_cnt_d = status_cnt_q;
        end
        // Fall-through: an empty FIFO presents the incoming word directly.
        if (FALL_THROUGH && (status_cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                status_cnt_d = status_cnt_q;
                read_ptr_d   = read_ptr_q;
                write_ptr_d  = write_ptr_q;
                mem_we       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_ptr_q   <= '0;
            write_ptr_q  <= '0;
            status_cnt_q <= '0;
        end else if (flush_i) begin
            read_ptr_q   <= '0;
            write_ptr_q  <= '0;
            status_cnt_q <= '0;
        end else begin
            read_ptr_q   <= read_ptr_d;
            write_ptr_q  <= write_ptr_d;
            status_cnt_q <= status_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[write_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mem_latency_rsp.sv
// Fixed-latency read responder: accepts AR bursts, returns address-pattern data
// exactly Latency cycles after acceptance, in acceptance order.
module mem_latency_rsp
    import mem_latency_rsp_pkg::*;
#(
    parameter int unsigned Latency   = DefaultLatency,
    parameter int unsigned MaxTxns   = DefaultMaxTxns,
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 512,
    parameter int unsigned IdWidth   = 3,
    parameter logic [63:0] MemBase   = 64'h0,
    parameter logic [63:0] MemSize   = 64'h1_0000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [DataWidth-1:0] r_data_o,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o
);

    localparam int unsigned          BeatBytes  = DataWidth / 8;
    localparam int unsigned          OffsetBits = $clog2(BeatBytes);
    localparam int unsigned          Lanes      = DataWidth / 64;
    localparam int unsigned          OccWidth   = $clog2(MaxTxns) + 1;
    localparam logic [OccWidth-1:0]  OccFull    = OccWidth'(MaxTxns);
    localparam logic [OccWidth-1:0]  OccOne     = OccWidth'(1);
    localparam logic [31:0]          DueAge     = 32'(Latency - 1);
    localparam logic [AddrWidth-1:0] OffsetMask = AddrWidth'(BeatBytes - 1);
    localparam rsp_state_e           FreshState = (Latency == 1) ? StBurst : StWait;

    rsp_state_e                  state_q, state_d;
    rd_txn_t                     head_q, head_d, fifo_rdata, new_txn;
    logic [7:0]                  beat_q, beat_d;
    logic [31:0]                 counter_q;
    logic [OccWidth-1:0]         occ_q, occ_d;
    logic                        ar_hs, r_hs, is_last, last_hs;
    logic                        load_from_ar, fifo_push, fifo_pop;
    logic                        fifo_full, fifo_empty;
    logic [$clog2(MaxTxns)-1:0]  fifo_usage;
    logic [AddrWidth-1:0]        base_addr, beat_addr;
    logic                        in_win;
    logic                        unused_sig;

    assign ar_ready_o = (occ_q != OccFull);
    assign ar_hs      = ar_valid_i & ar_ready_o;
    assign r_valid_o  = (state_q == StBurst);
    assign r_hs       = r_valid_o & r_ready_i;
    assign is_last    = (beat_q == head_q.len);
    assign last_hs    = r_hs & is_last;

    assign new_txn = '{addr: 64'(ar_addr_i), id: 8'(ar_id_i), len: ar_len_i, ts: counter_q};

    // The current burst lives in head_q; the FIFO holds the ones behind it, so
    // its output is the next head and can be judged due before the last beat pops.
    assign load_from_ar = ar_hs & ((state_q == StIdle) | (last_hs & fifo_empty));
    assign fifo_push    = ar_hs & ~load_from_ar;
    assign fifo_pop     = last_hs & ~fifo_empty;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   ($bits(rd_txn_t)),
        .DEPTH        (MaxTxns),
        .dtype        (rd_txn_t)
    ) u_txn_fifo (
        .clk_i      (clk_i),
        .rst_ni     (1'b1),
        .flush_i    (rst_i),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (new_txn),
        .push_i     (fifo_push),
        .data_o     (fifo_rdata),
        .pop_i      (fifo_pop)
    );

    always_comb begin
        occ_d = occ_q;
        if (ar_hs && !last_hs) begin
            occ_d = occ_q + OccOne;
        end else if (!ar_hs && last_hs) begin
            occ_d = occ_q - OccOne;
        end
    end

    // A head is due at ts+Latency, so BURST is entered one cycle earlier.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    head_d  = new_txn;
                    state_d = FreshState;
                end
            end
            StWait: begin
                if ((counter_q - head_q.ts) >= DueAge) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (r_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (is_last) begin
                        beat_d = '0;
                        if (!fifo_empty) begin
                            head_d  = fifo_rdata;
                            state_d = ((counter_q - fifo_rdata.ts) >= DueAge) ? StBurst : StWait;
                        end else if (ar_hs) begin
                            head_d  = new_txn;
                            state_d = FreshState;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            head_q    <= '0;
            beat_q    <= '0;
            counter_q <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            beat_q    <= beat_d;
            counter_q <= counter_q + 32'd1;
            occ_q     <= occ_d;
        end
    end

    assign base_addr = head_q.addr[AddrWidth-1:0] & ~OffsetMask;
    assign beat_addr = base_addr + (AddrWidth'(beat_q) << OffsetBits);
    assign in_win    = (head_q.addr >= MemBase) && ((head_q.addr - MemBase) < MemSize);

    always_comb begin
        r_data_o = '0;
        r_id_o   = '0;
        r_resp_o = RespOkay;
        r_last_o = 1'b0;
        if (state_q == StBurst) begin
            r_id_o   = head_q.id[IdWidth-1:0];
            r_last_o = is_last;
            if (in_win) begin
                for (int k = 0; k < Lanes; k++) begin
                    r_data_o[64*k +: 64] = 64'(beat_addr) + 64'(8 * k);
                end
            end else begin
                r_resp_o = RespDecErr;
            end
        end
    end

    assign unused_sig = ^{fifo_usage, fifo_full, head_q.id};

endmodule

// File: tb/tb_mem_latency_rsp.sv
// Directed bench for mem_latency_rsp (Latency=100, MaxTxns=4): vector table for
// single bursts plus stall, full-queue, counter-wrap and mid-burst-reset sequences.
module tb_mem_latency_rsp;

    localparam int Lat = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         ar_valid, ar_ready;
    logic [47:0]  ar_addr;
    logic [2:0]   ar_id;
    logic [7:0]   ar_len;
    logic         r_valid, r_ready;
    logic [511:0] r_data;
    logic [2:0]   r_id;
    logic [1:0]   r_resp;
    logic         r_last;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [2:0] exp_q[$];

    typedef struct {
        logic [47:0] addr;
        logic [2:0]  id;
        logic [7:0]  len;
        logic [1:0]  resp;
        logic [63:0] lane0;
    } vec_t;

    vec_t vecs[5];

    mem_latency_rsp #(
        .Latency (Lat),
        .MaxTxns (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ar_valid_i (ar_valid),
        .ar_ready_o (ar_ready),
        .ar_addr_i  (ar_addr),
        .ar_id_i    (ar_id),
        .ar_len_i   (ar_len),
        .r_valid_o  (r_valid),
        .r_ready_i  (r_ready),
        .r_data_o   (r_data),
        .r_id_o     (r_id),
        .r_resp_o   (r_resp),
        .r_last_o   (r_last)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ar_valid = 1'b0; ar_addr = '0; ar_id = '0; ar_len = '0; r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // driver: called just after a posedge; returns just after the handshake posedge
    task automatic send_ar(input logic [47:0] a, input logic [2:0] id, input logic [7:0] len,
                           output int t_hs);
        int g = 0;
        ar_valid = 1'b1; ar_addr = a; ar_id = id; ar_len = len;
        @(negedge clk);
        while (!ar_ready && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!ar_ready) begin
            n_tests++; n_fail++;
            $display("FAIL ar_timeout: ar_ready low for %0d cycles, expected handshake", g);
        end
        t_hs = cyc;
        @(posedge clk);
        #1 ar_valid = 1'b0;
    endtask

    // returns at the negedge of the first cycle with r_valid high
    task automatic wait_rvalid(input int max_cyc, output int t_v);
        int g = 0;
        @(negedge clk);
        while (!r_valid && g < max_cyc) begin
            @(negedge clk);
            g++;
        end
        if (!r_valid) begin
            n_tests++; n_fail++;
            $display("FAIL rvalid_timeout: r_valid low for %0d cycles, expected a beat", g);
        end
        t_v = cyc;
    endtask

    // called at a negedge where the first beat should be valid
    task automatic collect_burst(input logic [2:0] id, input logic [7:0] len,
                                 input logic [1:0] resp, input logic [63:0] lane0_first);
        for (int b = 0; b <= int'(len); b++) begin
            logic [63:0] e0;
            e0 = (resp == 2'b00) ? lane0_first + 64'(64 * b) : 64'h0;
            check("beat_valid", 64'(r_valid), 64'd1);
            check("beat_id", 64'(r_id), 64'(id));
            check("beat_resp", 64'(r_resp), 64'(resp));
            check("beat_lane0", r_data[63:0], e0);
            check("beat_lane1", r_data[127:64], (resp == 2'b00) ? e0 + 64'd8 : 64'h0);
            check("beat_lane7", r_data[511:448], (resp == 2'b00) ? e0 + 64'd56 : 64'h0);
            check("beat_last", 64'(r_last), (b == int'(len)) ? 64'd1 : 64'd0);
            r_ready = 1'b1;
            @(posedge clk);
            #1 r_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int t_hs, t_v, p, g, idx, nvalid;
        int t_seen[5];

        vecs[0] = '{addr: 48'h1000,         id: 3'd2, len: 8'd0, resp: 2'b00, lane0: 64'h1000};
        vecs[1] = '{addr: 48'h1007,         id: 3'd5, len: 8'd1, resp: 2'b00, lane0: 64'h1000};
        vecs[2] = '{addr: 48'h1_0000_0000,  id: 3'd1, len: 8'd1, resp: 2'b11, lane0: 64'h0};
        vecs[3] = '{addr: 48'hFFFF_FFC0,    id: 3'd7, len: 8'd2, resp: 2'b00, lane0: 64'hFFFF_FFC0};
        vecs[4] = '{addr: 48'hFFFF_FFFF_FFC0, id: 3'd6, len: 8'd0, resp: 2'b11, lane0: 64'h0};

        // reset state, during and after reset
        rst = 1'b1;
        ar_valid = 1'b0; ar_addr = '0; ar_id = '0; ar_len = '0; r_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_during_ar_ready", 64'(ar_ready), 64'd1);
        check("rst_during_r_valid", 64'(r_valid), 64'd0);
        do_reset();
        @(negedge clk);
        check("rst_ar_ready", 64'(ar_ready), 64'd1);
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_r_last", 64'(r_last), 64'd0);
        check("rst_r_data", 64'(|r_data), 64'd0);
        check("rst_r_id", 64'(r_id), 64'd0);
        check("rst_r_resp", 64'(r_resp), 64'd0);
        @(posedge clk); #1;

        // table-driven single bursts
        for (int i = 0; i < 5; i++) begin
            send_ar(vecs[i].addr, vecs[i].id, vecs[i].len, t_hs);
            wait_rvalid(300, t_v);
            check("vec_latency", 64'(t_v - t_hs), 64'(Lat));
            collect_burst(vecs[i].id, vecs[i].len, vecs[i].resp, vecs[i].lane0);
            check("vec_idle_after", 64'(r_valid), 64'd0);
            @(posedge clk); #1;
        end

        // stalled burst: outputs hold while r_ready is low
        send_ar(48'h40, 3'd4, 8'd3, t_hs);
        wait_rvalid(300, t_v);
        check("stall_latency", 64'(t_v - t_hs), 64'(Lat));
        for (int s = 0; s < 5; s++) begin
            check("stall_valid", 64'(r_valid), 64'd1);
            check("stall_lane0", r_data[63:0], 64'h40);
            check("stall_last", 64'(r_last), 64'd0);
            @(negedge clk);
        end
        collect_burst(3'd4, 8'd3, 2'b00, 64'h40);
        check("stall_idle_after", 64'(r_valid), 64'd0);
        @(posedge clk); #1;

        // full queue: four accepted, fifth waits until the cycle after the first pop
        for (int i = 0; i < 4; i++) begin
            send_ar(48'h2000 + 48'(i * 64), 3'(i), 8'd0, t_hs);
            exp_q.push_back(3'(i));
        end
        exp_q.push_back(3'd4);
        ar_valid = 1'b1; ar_addr = 48'h3000; ar_id = 3'd4; ar_len = 8'd0;
        @(negedge clk);
        check("full_ar_ready_low", 64'(ar_ready), 64'd0);
        wait_rvalid(300, p);
        check("full_still_low_at_beat", 64'(ar_ready), 64'd0);
        r_ready = 1'b1;
        g = 0; idx = 0;
        while (exp_q.size() > 0 && g < 400) begin
            if (g == 1) begin
                check("full_ar_ready_after_pop", 64'(ar_ready), 64'd1);
            end
            if (r_valid) begin
                check("order_id", 64'(r_id), 64'(exp_q.pop_front()));
                t_seen[idx] = cyc;
                idx++;
            end
            @(posedge clk);
            #1;
            if (g == 1) ar_valid = 1'b0;
            @(negedge clk);
            g++;
        end
        check("order_all_seen", 64'(exp_q.size()), 64'd0);
        for (int k = 1; k < 4; k++) begin
            check("b2b_no_bubble", 64'(t_seen[k] - p), 64'(k));
        end
        check("fifth_latency", 64'(t_seen[4] - (p + 1)), 64'(Lat));
        r_ready = 1'b0;
        @(posedge clk); #1;

        // counter wrap: preload near 2^32 then issue a burst
        @(negedge clk);
        force dut.counter_q = 32'hFFFF_FFF0;
        #1 release dut.counter_q;
        @(posedge clk); #1;
        send_ar(48'h5000, 3'd1, 8'd0, t_hs);
        wait_rvalid(300, t_v);
        check("wrap_latency", 64'(t_v - t_hs), 64'(Lat));
        collect_burst(3'd1, 8'd0, 2'b00, 64'h5000);
        @(posedge clk); #1;

        // reset in the middle of a len=7 burst with three more queued
        send_ar(48'h0, 3'd2, 8'd7, t_hs);
        for (int i = 0; i < 3; i++) send_ar(48'h6000, 3'd3, 8'd0, t_hs);
        wait_rvalid(300, t_v);
        for (int b = 0; b < 2; b++) begin
            r_ready = 1'b1;
            @(posedge clk);
            #1 r_ready = 1'b0;
            @(negedge clk);
        end
        check("midrst_beat2_lane0", r_data[63:0], 64'h80);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_r_valid", 64'(r_valid), 64'd0);
        check("midrst_ar_ready", 64'(ar_ready), 64'd1);
        check("midrst_r_last", 64'(r_last), 64'd0);
        check("midrst_r_data", 64'(|r_data), 64'd0);
        check("midrst_r_id", 64'(r_id), 64'd0);
        r_ready = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 250; c++) begin
            if (r_valid) nvalid++;
            @(negedge clk);
        end
        check("midrst_no_stale_beats", 64'(nvalid), 64'd0);
        r_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
